// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit path: FSM state
// encoding, byte width and the bit-period helper.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_PARITY    = 3'd5
  } rx_state_e;

  // Clocks per serial bit, integer division (caller guarantees >= 4).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry an extra wrap
// bit so full/empty fall out of the pointer difference. A push on a full
// FIFO is accepted only when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, cnt_d;
  logic        empty_q, empty_d, full_q, full_d;
  logic        do_push, do_pop;

  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  // Pointer/memory update; flags come from the post-update occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop)
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    cnt_d   = wr_d - rd_d;
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_C);
  end

  // FIFO state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a FWFT byte FIFO, with sticky
// framing and overrun flags. Defining UART_RX_PARITY_EN switches framing
// to 8E1 and adds a sticky parity_err output; bad-parity bytes are still
// delivered.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx,
  output logic [BYTE_W-1:0] SerialData_out,
  output logic              SerialEmpty,
  output logic              SerialFull,
  input  logic              SerialRead,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int TW  = $clog2(CPB);
  localparam logic [TW-1:0] HALF_M1 = TW'(CPB/2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CPB - 1);

  rx_state_e         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              push_q, push_d;
  logic [1:0]        sync_q, sync_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              frame_set, overrun_set;
  logic              rx_s, tick_half, tick_full;
`ifdef UART_RX_PARITY_EN
  logic              parity_err_q, parity_err_d, parity_set;
`endif

  assign rx_s      = sync_q[1];
  assign tick_half = (timer_q == HALF_M1);
  assign tick_full = (timer_q == FULL_M1);

  // Two-flop synchroniser on the asynchronous line.
  always_comb sync_d = {sync_q[0], rx};

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      push_q      <= 1'b0;
      sync_q      <= 2'b11;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      push_q      <= push_d;
      sync_q      <= sync_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state: start is re-checked at mid-bit, stop is sampled one bit after bit 7 (or parity).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rx_s) state_d = S_START;
      S_START:     if (tick_half) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (tick_full && idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY:    if (tick_full) state_d = S_STOP;
`else
      S_DATA:      if (tick_full && idx_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:      if (tick_full) state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Per-state outputs: bit timer, data capture, push request and error strobes.
  always_comb begin
    timer_d   = timer_q + TW'(1);
    idx_d     = idx_q;
    data_d    = data_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_set = 1'b0;
`endif
    case (state_q)
      S_START: if (tick_half) begin
        timer_d = '0;
        idx_d   = '0;
      end
      S_DATA: if (tick_full) begin
        timer_d        = '0;
        data_d[idx_q]  = rx_s;
        idx_d          = idx_q + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick_full) begin
        timer_d    = '0;
        parity_set = (rx_s != ^data_q);
      end
`endif
      S_STOP: if (tick_full) begin
        timer_d   = '0;
        push_d    = rx_s;
        frame_set = ~rx_s;
      end
      default: timer_d = '0;
    endcase
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_comb begin
    overrun_set = push_q & SerialFull & ~(SerialRead & ~SerialEmpty);
    frame_err_d = frame_set   | (frame_err_q & ~err_clr);
    overrun_d   = overrun_set | (overrun_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_set | (parity_err_q & ~err_clr);
`endif
  end

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(BYTE_W)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push_q),
    .pop    (SerialRead),
    .wdata  (data_q),
    .rdata  (SerialData_out),
    .empty  (SerialEmpty),
    .full   (SerialFull)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random frames against a queue-based
// model of the received byte stream and the sticky error flags.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int CPB   = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       SerialRead = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] SerialData_out;
  logic       SerialEmpty, SerialFull, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .SerialData_out(SerialData_out),
    .SerialEmpty   (SerialEmpty),
    .SerialFull    (SerialFull),
    .SerialRead    (SerialRead),
    .err_clr       (err_clr),
    .frame_err     (frame_err),
    .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err    (parity_err)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int lat, lat0;

  // reference model
  logic [7:0] q[$];
  bit m_fe, m_ov, m_pe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop, input logic par);
    if (!stop) m_fe = 1;
    else begin
`ifdef UART_RX_PARITY_EN
      if (par != ^b) m_pe = 1;
`endif
      if (q.size() < DEPTH) q.push_back(b);
      else m_ov = 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_empty"}, SerialEmpty, q.size() == 0);
    chk({tag, "_full"}, SerialFull, q.size() == DEPTH);
    chk({tag, "_frame_err"}, frame_err, m_fe);
    chk({tag, "_overrun"}, overrun, m_ov);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_parity_err"}, parity_err, m_pe);
`endif
    if (q.size() > 0) chk({tag, "_head"}, SerialData_out, q[0]);
  endtask

  // Drive one frame, one bit per CPB clocks, then idle. SerialRead is high
  // during cycle rd_at (-1: never). lat = first cycle whose end edge drops SerialEmpty.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input int rd_at);
    logic [10:0] fr;
    int nb;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
    fr[9] = par; fr[10] = stop; nb = 11;
`else
    fr[9] = stop; fr[10] = par; nb = 10;
`endif
    lat = -1;
    for (int c = 0; c < nb*CPB + 20; c++) begin
      rx = (c < nb*CPB) ? fr[c/CPB] : 1'b1;
      SerialRead = (c == rd_at);
      @(posedge clock); #1;
      if (lat < 0 && !SerialEmpty) lat = c;
    end
    SerialRead = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    send_frame(b, stop, ^b, -1);
    model_rx(b, stop, ^b);
  endtask

  task automatic do_read(input string tag);
    chk({tag, "_rd_empty"}, SerialEmpty, q.size() == 0);
    if (q.size() > 0) chk({tag, "_rd_data"}, SerialData_out, q[0]);
    SerialRead = 1'b1;
    @(posedge clock); #1;
    SerialRead = 1'b0;
    if (q.size() > 0) q.delete(0);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    m_fe = 0; m_ov = 0; m_pe = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs, rp;
    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_empty", SerialEmpty, 1'b1);
    chk("rst_full", SerialFull, 1'b0);
    chk("rst_data", SerialData_out, 8'h00);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    idle(5);

    // single byte and latency
    send(8'hA5, 1'b1);
    lat0 = lat;
    chk("a5_latency_window", (lat0 >= 94 && lat0 <= 102), 1'b1);
    check_state("a5");
    do_read("a5");
    check_state("a5_popped");

    // short glitch is a false start
    rx = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    idle(40);
    check_state("glitch");

    // read while empty is ignored
    do_read("empty_read");
    check_state("empty_read_after");

    // framing error, recovery, clear
    send(8'h3C, 1'b0);
    check_state("frame_bad");
    send(8'h11, 1'b1);
    check_state("frame_next");
    do_read("frame_next");
    clear_errs();
    check_state("frame_clr");

    // overrun: five bytes, no reads
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      check_state($sformatf("fill%0d", i));
    end
    for (int i = 0; i < 4; i++) do_read($sformatf("ovr_rd%0d", i));
    check_state("ovr_drained");
    clear_errs();
    check_state("ovr_clr");

    // pop on the exact push cycle while full: no overrun
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    check_state("sim_full");
    send_frame(8'h05, 1'b1, ^8'h05, lat0);
    q.delete(0);
    model_rx(8'h05, 1'b1, ^8'h05);
    check_state("sim_after");
    for (int i = 0; i < 4; i++) do_read($sformatf("sim_rd%0d", i));
    check_state("sim_drained");

    // random frames with random reads
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = (^rb) ^ ($urandom_range(0, 4) == 0);
      send_frame(rb, rs, rp, -1);
      model_rx(rb, rs, rp);
      check_state($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) do_read($sformatf("rnd_rd%0d", i));
    end
    while (q.size() > 0) do_read("rnd_drain");
    clear_errs();
    check_state("rnd_clr");

`ifdef UART_RX_PARITY_EN
    // wrong parity still delivers the byte; correct parity leaves flag set
    send_frame(8'h07, 1'b1, 1'b0, -1);
    model_rx(8'h07, 1'b1, 1'b0);
    check_state("par_bad");
    send_frame(8'h07, 1'b1, 1'b1, -1);
    model_rx(8'h07, 1'b1, 1'b1);
    check_state("par_good");
    while (q.size() > 0) do_read("par_drain");
    clear_errs();
    check_state("par_clr");
`endif

    // reset in the middle of a frame drops the partial byte
    rx = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    q.delete();
    m_fe = 0; m_ov = 0; m_pe = 0;
    idle(150);
    check_state("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
